// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port data-memory arbiter.
// It carries two requester ports (CPU = port 0, DMA = port 1) and the
// single-port memory side. The slave modport is the arbiter's view.
// The master modport is the view of the environment (requesters plus memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wr;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wr;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              mem_rd_wr;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] mem_entrada;
    logic [DATA_W-1:0] mem_saida;

    modport slave (
        input  req0_valid, req0_wr, req0_addr, req0_wdata,
        input  req1_valid, req1_wr, req1_addr, req1_wdata,
        input  mem_saida,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_rd_wr, mem_endereco, mem_entrada
    );

    modport master (
        output req0_valid, req0_wr, req0_addr, req0_wdata,
        output req1_valid, req1_wr, req1_addr, req1_wdata,
        output mem_saida,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_rd_wr, mem_endereco, mem_entrada
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that merges two requesters onto one data memory.
// The memory has a registered read.
// Stage 1 registers the granted access and drives the memory pins.
// Stage 2 tracks which port gets the read data.
// The read data arrives on mem_saida in the same cycle as stage 2.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic           Clk,
    input  logic           Rst,
    dmem_arbiter_if.slave  bus
);
    // Pointer to the port granted on the last transfer (1 => port 0 wins next tie).
    logic              last_grant_q, last_grant_d;
    // Stage 1: access currently presented to memory.
    logic              s1_wr_q, s1_wr_d;
    logic              s1_rd_q, s1_rd_d;
    logic              s1_tag_q, s1_tag_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    // Stage 2: a read whose data is on mem_saida this cycle.
    logic              s2_valid_q, s2_valid_d;
    logic              s2_tag_q, s2_tag_d;

    logic              grant0, grant1, xfer;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grant: a lone valid wins at once; on a tie, the port not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    // A grant always coincides with its valid, so any grant is a transfer.
    assign xfer     = grant0 | grant1;
    assign sel_wr   = grant1 ? bus.req1_wr    : bus.req0_wr;
    assign sel_addr = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign sel_data = grant1 ? bus.req1_wdata : bus.req0_wdata;

    // Next state: load stage 1 on a transfer, advance stage 2 every cycle.
    always_comb begin
        last_grant_d = last_grant_q;
        s1_wr_d      = 1'b0;
        s1_rd_d      = 1'b0;
        s1_tag_d     = s1_tag_q;
        s1_addr_d    = s1_addr_q;
        s1_data_d    = s1_data_q;
        s2_valid_d   = s1_rd_q;
        s2_tag_d     = s1_tag_q;
        if (xfer) begin
            last_grant_d = grant1;
            s1_wr_d      = sel_wr;
            s1_rd_d      = !sel_wr;
            s1_tag_d     = grant1;
            s1_addr_d    = sel_addr;
            s1_data_d    = sel_data;
        end
    end

    // State registers.
    // Reset drops stage 1 and stage 2 at once, so in-flight accesses are discarded.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_grant_q <= 1'b1;
            s1_wr_q      <= 1'b0;
            s1_rd_q      <= 1'b0;
            s1_tag_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_tag_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_wr_q      <= s1_wr_d;
            s1_rd_q      <= s1_rd_d;
            s1_tag_q     <= s1_tag_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign bus.mem_rd_wr    = s1_wr_q;
    assign bus.mem_endereco = s1_addr_q;
    assign bus.mem_entrada  = s1_data_q;
    assign bus.rsp0_valid   = s2_valid_q && !s2_tag_q;
    assign bus.rsp1_valid   = s2_valid_q &&  s2_tag_q;
    assign bus.rsp0_rdata   = bus.mem_saida;
    assign bus.rsp1_rdata   = bus.mem_saida;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
// It includes a registered-read memory behind the arbiter.
// A transaction-level reference model predicts grants and read data.
// Directed sequences, a grant table and random traffic drive the design.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk;
    logic rst;
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory placed behind the arbiter: synchronous write, registered read.
    logic [DW-1:0] devmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_rd_wr)
            devmem[bus.mem_endereco] <= bus.mem_entrada;
        bus.mem_saida <= devmem[bus.mem_endereco];
    end

    // Reference model: memory contents seen in transfer order, plus pending responses.
    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;
    rsp_t          rq[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    bit            m_last;
    bit            pend_v;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    int            cyc = 0;

    // A write lands one edge after its transfer; a reset in between discards it.
    initial begin
        bit            e0, e1, x0, x1, p, w;
        logic [DW-1:0] ed, wd;
        logic [AW-1:0] ad;
        m_last = 1'b1;
        pend_v = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                rq.delete();
                pend_v = 1'b0;
                m_last = 1'b1;
            end else begin
                if (pend_v) begin
                    model_mem[pend_a] = pend_d;
                    pend_v = 1'b0;
                end
                e0 = 1'b0;
                e1 = 1'b0;
                ed = '0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    if (rq[0].port) e1 = 1'b1; else e0 = 1'b1;
                    ed = rq[0].data;
                    void'(rq.pop_front());
                end
                chk("mon_rsp0_valid", {31'b0, bus.rsp0_valid}, {31'b0, e0});
                chk("mon_rsp1_valid", {31'b0, bus.rsp1_valid}, {31'b0, e1});
                if (e0) chk("mon_rsp0_rdata", bus.rsp0_rdata, ed);
                if (e1) chk("mon_rsp1_rdata", bus.rsp1_rdata, ed);
                if (bus.req0_valid && bus.req1_valid) begin
                    x0 = m_last;
                    x1 = !m_last;
                end else begin
                    x0 = bus.req0_valid;
                    x1 = bus.req1_valid;
                end
                chk("mon_ready0", {31'b0, bus.req0_ready}, {31'b0, x0});
                chk("mon_ready1", {31'b0, bus.req1_ready}, {31'b0, x1});
                if (x0 || x1) begin
                    p  = x1;
                    w  = p ? bus.req1_wr    : bus.req0_wr;
                    ad = p ? bus.req1_addr  : bus.req0_addr;
                    wd = p ? bus.req1_wdata : bus.req0_wdata;
                    if (w) begin
                        pend_v = 1'b1;
                        pend_a = ad;
                        pend_d = wd;
                    end else begin
                        rq.push_back('{port: p, data: model_mem[ad], due: cyc + 2});
                    end
                    m_last = p;
                end
                cyc++;
            end
        end
    end

    task automatic idle();
        bus.req0_valid = 1'b0; bus.req0_wr = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_wr = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    task automatic drive(input bit v0, input bit w0, input int a0, input logic [DW-1:0] d0,
                         input bit v1, input bit w1, input int a1, input logic [DW-1:0] d1);
        bus.req0_valid = v0; bus.req0_wr = w0; bus.req0_addr = AW'(a0); bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_wr = w1; bus.req1_addr = AW'(a1); bus.req1_wdata = d1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit v0;
        bit v1;
        bit r0;
        bit r1;
    } vec_t;
    vec_t tbl [10];

    bit rdy0_s, rdy1_s;

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        idle();
        for (int i = 0; i < (1 << AW); i++) begin
            devmem[i]    = '0;
            model_mem[i] = '0;
        end
        devmem[0] = 2001; model_mem[0] = 2001;
        devmem[1] = 4001; model_mem[1] = 4001;
        devmem[2] = 5001; model_mem[2] = 5001;
        devmem[3] = 3001; model_mem[3] = 3001;

        // Reset values, with both requesters asking.
        repeat (3) @(negedge clk);
        drive(1, 1, 7, 32'h55, 1, 1, 9, 32'h66);
        #1;
        chk("rst_ready0", {31'b0, bus.req0_ready}, 0);
        chk("rst_ready1", {31'b0, bus.req1_ready}, 0);
        chk("rst_mem_rd_wr", {31'b0, bus.mem_rd_wr}, 0);
        chk("rst_mem_endereco", {22'b0, bus.mem_endereco}, 0);
        chk("rst_mem_entrada", bus.mem_entrada, 0);
        chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 0);
        chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 0);
        idle();
        rst = 1'b0;

        // Port 0 reads address 0 right after reset.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("first_ready0", {31'b0, bus.req0_ready}, 1);
        chk("first_ready1", {31'b0, bus.req1_ready}, 0);
        @(negedge clk);
        idle();
        #1;
        chk("first_rsp_early", {31'b0, bus.rsp0_valid}, 0);
        @(negedge clk);
        #1;
        chk("first_rsp0_valid", {31'b0, bus.rsp0_valid}, 1);
        chk("first_rsp0_rdata", bus.rsp0_rdata, 2001);
        chk("first_rsp1_valid", {31'b0, bus.rsp1_valid}, 0);
        @(negedge clk);
        #1;
        chk("first_rsp_once", {31'b0, bus.rsp0_valid}, 0);

        // Both ports read continuously: grants and responses alternate.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            drive(1, 0, 1, 0, 1, 0, 2, 0);
            #1;
            chk("rr_ready0", {31'b0, bus.req0_ready}, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", {31'b0, bus.req1_ready}, (i % 2 == 1) ? 1 : 0);
            if (i >= 2) begin
                chk("rr_rsp0_valid", {31'b0, bus.rsp0_valid}, (i % 2 == 0) ? 1 : 0);
                chk("rr_rsp1_valid", {31'b0, bus.rsp1_valid}, (i % 2 == 1) ? 1 : 0);
                chk("rr_rdata", (i % 2 == 0) ? bus.rsp0_rdata : bus.rsp1_rdata,
                    (i % 2 == 0) ? 4001 : 5001);
            end
        end
        @(negedge clk);
        idle();

        // Port 1 writes address 3, then port 0 reads it on the next cycle.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 3, 7);
        @(negedge clk);
        drive(1, 0, 3, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("raw_rsp0_valid", {31'b0, bus.rsp0_valid}, 1);
        chk("raw_rsp0_rdata", bus.rsp0_rdata, 7);

        // Port 0 writes and then reads the same address back-to-back.
        @(negedge clk);
        drive(1, 1, 4, 32'hABCD, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("wr_rd_rdata", bus.rsp0_rdata, 32'hABCD);

        // Port 0 alone for 5 cycles: granted every cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 0, i, 0, 0, 0, 0, 0);
            #1;
            chk("solo_ready0", {31'b0, bus.req0_ready}, 1);
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        // Reset while a write to address 5 sits in stage 1.
        @(negedge clk);
        drive(1, 1, 5, 32'h1234, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("midrst_wr_before", {31'b0, bus.mem_rd_wr}, 1);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_mem_rd_wr", {31'b0, bus.mem_rd_wr}, 0);
        chk("midrst_mem_endereco", {22'b0, bus.mem_endereco}, 0);
        chk("midrst_mem_entrada", bus.mem_entrada, 0);
        chk("midrst_rsp0_valid", {31'b0, bus.rsp0_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        chk("midrst_rd_valid", {31'b0, bus.rsp0_valid}, 1);
        chk("midrst_rd_rdata", bus.rsp0_rdata, 0);

        // Grant table from a fresh reset (port 0 wins the first tie).
        tbl[0] = '{1, 1, 1, 0};
        tbl[1] = '{1, 1, 0, 1};
        tbl[2] = '{0, 1, 0, 1};
        tbl[3] = '{1, 1, 1, 0};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 1};
        tbl[7] = '{0, 1, 0, 1};
        tbl[8] = '{1, 1, 1, 0};
        tbl[9] = '{0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].v0, 0, i, 0, tbl[i].v1, 0, i + 1, 0);
            #1;
            chk($sformatf("tbl%0d_ready0", i), {31'b0, bus.req0_ready}, {31'b0, tbl[i].r0});
            chk($sformatf("tbl%0d_ready1", i), {31'b0, bus.req1_ready}, {31'b0, tbl[i].r1});
        end
        @(negedge clk);
        idle();

        // Random traffic; a request is held unchanged until it is accepted.
        rdy0_s = 1'b1;
        rdy1_s = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!(bus.req0_valid && !rdy0_s)) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_wr    = 1'($urandom_range(0, 1));
                bus.req0_addr  = AW'($urandom_range(0, 15));
                bus.req0_wdata = $urandom;
            end
            if (!(bus.req1_valid && !rdy1_s)) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_wr    = 1'($urandom_range(0, 1));
                bus.req1_addr  = AW'($urandom_range(0, 15));
                bus.req1_wdata = $urandom;
            end
            #1;
            rdy0_s = bus.req0_ready;
            rdy1_s = bus.req1_ready;
        end
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
